// File: rtl/trap_csr_seq_pkg.sv
// trap_csr_seq_pkg
//   Shared definitions for the trap-entry sequencer: CSR addresses, mstatus
//   bit positions, FSM state encoding, latched trap context and the mstatus
//   update applied on machine-mode trap entry.
package trap_csr_seq_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int CSR_ADDR_WIDTH = 12;

  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FLUSH     = 3'd1,
    S_W_MEPC    = 3'd2,
    S_W_MCAUSE  = 3'd3,
    S_W_MTVAL   = 3'd4,
    S_W_MSTATUS = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  // Snapshot of everything the sequence needs, taken when the trap is accepted
  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] cause;
    logic [DATA_WIDTH-1:0] tval;
    logic [DATA_WIDTH-1:0] mstatus;
    logic [DATA_WIDTH-1:0] mtvec;
  } trap_ctx_t;

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= machine mode
  function automatic logic [DATA_WIDTH-1:0] mstatus_on_trap(input logic [DATA_WIDTH-1:0] m);
    logic [DATA_WIDTH-1:0] r;
    r = m;
    r[MSTATUS_MPIE] = m[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/trap_csr_seq_trap_vector_calc.sv
// trap_vector_calc
//   Combinational trap target computation from mtvec and mcause.
//   Config macro: TRAP_VECTORED_EN -- when defined, vectored mode
//   (mtvec[1:0]==2'b01) sends interrupts to base + 4*cause; otherwise the
//   target is always the 4-byte-aligned mtvec base.
// Ports:
//   mtvec   in  32  latched mtvec
//   cause   in  32  latched mcause (bit31 = interrupt)
//   target  out 32  redirect PC
module trap_vector_calc
  import trap_csr_seq_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] mtvec,
  input  logic [DATA_WIDTH-1:0] cause,
  output logic [DATA_WIDTH-1:0] target
);

  logic [DATA_WIDTH-1:0] base;
  assign base = {mtvec[DATA_WIDTH-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // cause[30] falls off the top of the shift (32-bit wrap)
  logic unused_ok;
  assign unused_ok = cause[30];

  always_comb begin
    target = base;
    if (mtvec[1:0] == 2'b01 && cause[DATA_WIDTH-1])
      target = base + {cause[DATA_WIDTH-3:0], 2'b00};
  end
`else
  logic unused_ok;
  assign unused_ok = ^{cause, mtvec[1:0]};

  assign target = base;
`endif

endmodule

// File: rtl/trap_csr_seq.sv
// trap_csr_seq
//   Trap-entry sequencer sharing the single CSR write port between the
//   writeback stage and machine-mode trap entry. An accepted trap flushes the
//   pipeline for one cycle, writes mepc/mcause/mtval/mstatus one per cycle
//   (yielding to writeback whenever it writes), then redirects fetch and acks.
//   Config macro: TRAP_VECTORED_EN (handled in trap_vector_calc).
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   wb_csr_we/waddr/wdata_i      writeback CSR write request
//   trap_req_i                   level trap request, held until trap_ack_o
//   trap_pc/cause/tval_i         trap context
//   mstatus_i, mtvec_i           current CSR values
//   csr_we/waddr/wdata_o         CSR file write port
//   flush_int_o                  one-cycle pipeline flush
//   stall_o, busy_o              sequence in progress
//   redirect_o, redirect_pc_o    one-cycle fetch redirect and target
//   trap_ack_o                   one-cycle completion pulse
module trap_csr_seq
  import trap_csr_seq_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wb_csr_we_i,
  input  logic [CSR_ADDR_WIDTH-1:0] wb_csr_waddr_i,
  input  logic [DATA_WIDTH-1:0]     wb_csr_wdata_i,
  input  logic                      trap_req_i,
  input  logic [DATA_WIDTH-1:0]     trap_pc_i,
  input  logic [DATA_WIDTH-1:0]     trap_cause_i,
  input  logic [DATA_WIDTH-1:0]     trap_tval_i,
  input  logic [DATA_WIDTH-1:0]     mstatus_i,
  input  logic [DATA_WIDTH-1:0]     mtvec_i,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [DATA_WIDTH-1:0]     csr_wdata_o,
  output logic                      flush_int_o,
  output logic                      stall_o,
  output logic                      busy_o,
  output logic                      redirect_o,
  output logic [DATA_WIDTH-1:0]     redirect_pc_o,
  output logic                      trap_ack_o
);

  state_t                state, state_nxt;
  trap_ctx_t             ctx;
  logic [DATA_WIDTH-1:0] target;

  trap_vector_calc u_vec (
    .mtvec  (ctx.mtvec),
    .cause  (ctx.cause),
    .target (target)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      ctx   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && trap_req_i)
        ctx <= '{pc: trap_pc_i, cause: trap_cause_i, tval: trap_tval_i,
                 mstatus: mstatus_i, mtvec: mtvec_i};
    end
  end

  // Write states only advance when the port was actually theirs this cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (trap_req_i) state_nxt = S_FLUSH;
      S_FLUSH:     state_nxt = S_W_MEPC;
      S_W_MEPC:    if (!wb_csr_we_i) state_nxt = S_W_MCAUSE;
      S_W_MCAUSE:  if (!wb_csr_we_i) state_nxt = S_W_MTVAL;
      S_W_MTVAL:   if (!wb_csr_we_i) state_nxt = S_W_MSTATUS;
      S_W_MSTATUS: if (!wb_csr_we_i) state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode from registered state; reset masks everything so a
  // sequence cut short by rst_i never emits a partial write or ack.
  always_comb begin
    csr_we_o      = 1'b0;
    csr_waddr_o   = '0;
    csr_wdata_o   = '0;
    flush_int_o   = 1'b0;
    busy_o        = 1'b0;
    stall_o       = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    trap_ack_o    = 1'b0;
    if (!rst_i) begin
      busy_o  = (state != S_IDLE);
      stall_o = (state != S_IDLE);
      if (wb_csr_we_i) begin
        csr_we_o    = 1'b1;
        csr_waddr_o = wb_csr_waddr_i;
        csr_wdata_o = wb_csr_wdata_i;
      end else begin
        case (state)
          S_W_MEPC: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MEPC;
            csr_wdata_o = {ctx.pc[DATA_WIDTH-1:2], 2'b00};
          end
          S_W_MCAUSE: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MCAUSE;
            csr_wdata_o = ctx.cause;
          end
          S_W_MTVAL: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MTVAL;
            csr_wdata_o = ctx.tval;
          end
          S_W_MSTATUS: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MSTATUS;
            csr_wdata_o = mstatus_on_trap(ctx.mstatus);
          end
          default: ;
        endcase
      end
      case (state)
        S_FLUSH: flush_int_o = 1'b1;
        S_DONE: begin
          redirect_o    = 1'b1;
          trap_ack_o    = 1'b1;
          redirect_pc_o = target;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_csr_seq.sv
// tb_trap_csr_seq
//   Table-driven vectors for the basic sequence, hand-written multi-cycle
//   corner cases, then randomized stimulus against a queue-based model.
module tb_trap_csr_seq;

`ifdef TRAP_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  localparam logic [31:0] EXP_T3 = VEC ? 32'h32C : 32'h300;
  localparam logic [31:0] EXP_T5 = VEC ? 32'h21C : 32'h200;

  typedef struct packed {
    logic rst; logic wb_we; logic [11:0] wa; logic [31:0] wd; logic req;
    logic [31:0] pc; logic [31:0] cause; logic [31:0] tval;
    logic [31:0] mst; logic [31:0] mtvec;
  } in_t;

  typedef struct packed {
    logic we; logic [11:0] wa; logic [31:0] wd; logic flush; logic busy;
    logic stall; logic redir; logic [31:0] rpc; logic ack;
  } out_t;

  typedef struct packed { in_t i; out_t o; } vec_t;

  typedef struct { int kind; logic [11:0] a; logic [31:0] d; } act_t;

  logic        clk = 1'b0;
  logic        rst_i, wb_csr_we_i, trap_req_i;
  logic [11:0] wb_csr_waddr_i;
  logic [31:0] wb_csr_wdata_i, trap_pc_i, trap_cause_i, trap_tval_i, mstatus_i, mtvec_i;
  logic        csr_we_o, flush_int_o, stall_o, busy_o, redirect_o, trap_ack_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o, redirect_pc_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_csr_seq dut (
    .clk_i(clk), .rst_i(rst_i),
    .wb_csr_we_i(wb_csr_we_i), .wb_csr_waddr_i(wb_csr_waddr_i), .wb_csr_wdata_i(wb_csr_wdata_i),
    .trap_req_i(trap_req_i), .trap_pc_i(trap_pc_i), .trap_cause_i(trap_cause_i),
    .trap_tval_i(trap_tval_i), .mstatus_i(mstatus_i), .mtvec_i(mtvec_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .flush_int_o(flush_int_o), .stall_o(stall_o), .busy_o(busy_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .trap_ack_o(trap_ack_o)
  );

  function automatic in_t ix(input logic rst, input logic wb_we, input logic [11:0] wa,
                             input logic [31:0] wd, input logic req, input logic [31:0] pc,
                             input logic [31:0] cause, input logic [31:0] tval,
                             input logic [31:0] mst, input logic [31:0] mtvec);
    return '{rst: rst, wb_we: wb_we, wa: wa, wd: wd, req: req, pc: pc, cause: cause,
             tval: tval, mst: mst, mtvec: mtvec};
  endfunction

  function automatic out_t ex(input logic we, input logic [11:0] wa, input logic [31:0] wd,
                              input logic flush, input logic busy, input logic redir,
                              input logic [31:0] rpc, input logic ack);
    return '{we: we, wa: wa, wd: wd, flush: flush, busy: busy, stall: busy,
             redir: redir, rpc: rpc, ack: ack};
  endfunction

  function automatic vec_t row(input in_t i, input out_t o);
    return '{i: i, o: o};
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("we=%0b a=%h d=%h flush=%0b busy=%0b stall=%0b redir=%0b rpc=%h ack=%0b",
                     o.we, o.wa, o.wd, o.flush, o.busy, o.stall, o.redir, o.rpc, o.ack);
  endfunction

  // Address/data only matter when a write is expected
  function automatic bit same(input out_t a, input out_t e);
    if (a.we !== e.we) return 1'b0;
    if (e.we && (a.wa !== e.wa || a.wd !== e.wd)) return 1'b0;
    return a.flush === e.flush && a.busy === e.busy && a.stall === e.stall &&
           a.redir === e.redir && a.rpc === e.rpc && a.ack === e.ack;
  endfunction

  // Drive one cycle's inputs after the falling edge, then check the outputs
  task automatic cyc(input in_t i, input out_t e, input string name);
    out_t a;
    @(negedge clk);
    rst_i = i.rst; wb_csr_we_i = i.wb_we; wb_csr_waddr_i = i.wa; wb_csr_wdata_i = i.wd;
    trap_req_i = i.req; trap_pc_i = i.pc; trap_cause_i = i.cause; trap_tval_i = i.tval;
    mstatus_i = i.mst; mtvec_i = i.mtvec;
    #2;
    a = '{we: csr_we_o, wa: csr_waddr_o, wd: csr_wdata_o, flush: flush_int_o, busy: busy_o,
          stall: stall_o, redir: redirect_o, rpc: redirect_pc_o, ack: trap_ack_o};
    checks++;
    if (!same(a, e)) begin
      errors++;
      $display("FAIL %s: got %s ; want %s", name, fmt(a), fmt(e));
    end
  endtask

  // Reference: an accepted trap becomes a list of pending actions
  // (flush, four writes, done); writes wait while writeback owns the port.
  function automatic logic [31:0] ref_target(input logic [31:0] mtvec, input logic [31:0] cause);
    logic [31:0] base, off;
    base = mtvec & ~32'h3;
    off  = (cause & 32'h7FFF_FFFF) << 2;
    if (VEC && mtvec[1:0] == 2'b01 && cause[31]) return base + off;
    return base;
  endfunction

  function automatic logic [31:0] ref_mstatus(input logic [31:0] m);
    return (m & ~32'h0000_1888) | 32'h0000_1800 | ((m & 32'h8) << 4);
  endfunction

  act_t q[$];

  function automatic out_t model_out(input in_t i);
    out_t o;
    o = ex(0, 0, 0, 0, 0, 0, 0, 0);
    if (i.rst) return o;
    o.busy  = (q.size() != 0);
    o.stall = o.busy;
    if (i.wb_we) begin o.we = 1; o.wa = i.wa; o.wd = i.wd; end
    if (q.size() != 0) begin
      case (q[0].kind)
        0: o.flush = 1;
        1: if (!i.wb_we) begin o.we = 1; o.wa = q[0].a; o.wd = q[0].d; end
        default: begin o.redir = 1; o.ack = 1; o.rpc = q[0].d; end
      endcase
    end
    return o;
  endfunction

  task automatic model_step(input in_t i);
    if (i.rst) q.delete();
    else if (q.size() == 0) begin
      if (i.req) begin
        q.push_back('{0, 12'h000, 32'h0});
        q.push_back('{1, 12'h341, i.pc & ~32'h3});
        q.push_back('{1, 12'h342, i.cause});
        q.push_back('{1, 12'h343, i.tval});
        q.push_back('{1, 12'h300, ref_mstatus(i.mst)});
        q.push_back('{2, 12'h000, ref_target(i.mtvec, i.cause)});
      end
    end else if (!(q[0].kind == 1 && i.wb_we)) void'(q.pop_front());
  endtask

  vec_t tbl[$];
  out_t o0;
  in_t  t;

  initial begin
    rst_i = 1; wb_csr_we_i = 0; wb_csr_waddr_i = 0; wb_csr_wdata_i = 0; trap_req_i = 0;
    trap_pc_i = 0; trap_cause_i = 0; trap_tval_i = 0; mstatus_i = 0; mtvec_i = 0;
    o0 = ex(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    // Basic sequence, then trap request coinciding with a writeback write
    tbl.push_back(row(ix(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), o0));
    tbl.push_back(row(ix(0, 0, 0, 0, 1, 32'h100, 32'h2, 32'hDEAD, 32'h8, 32'h200), o0));
    tbl.push_back(row(ix(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 1, 0, 0, 0)));
    tbl.push_back(row(ix(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(1, 12'h341, 32'h100, 0, 1, 0, 0, 0)));
    tbl.push_back(row(ix(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(1, 12'h342, 32'h2, 0, 1, 0, 0, 0)));
    tbl.push_back(row(ix(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(1, 12'h343, 32'hDEAD, 0, 1, 0, 0, 0)));
    tbl.push_back(row(ix(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(1, 12'h300, 32'h1880, 0, 1, 0, 0, 0)));
    tbl.push_back(row(ix(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 1, 1, 32'h200, 1)));
    tbl.push_back(row(ix(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), o0));
    tbl.push_back(row(ix(0, 1, 12'h305, 32'h1234, 1, 32'h107, 32'h8000000B, 0, 0, 32'h301),
                      ex(1, 12'h305, 32'h1234, 0, 0, 0, 0, 0)));
    tbl.push_back(row(ix(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 1, 0, 0, 0)));
    tbl.push_back(row(ix(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(1, 12'h341, 32'h104, 0, 1, 0, 0, 0)));
    tbl.push_back(row(ix(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(1, 12'h342, 32'h8000000B, 0, 1, 0, 0, 0)));
    tbl.push_back(row(ix(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(1, 12'h343, 32'h0, 0, 1, 0, 0, 0)));
    tbl.push_back(row(ix(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(1, 12'h300, 32'h1800, 0, 1, 0, 0, 0)));
    tbl.push_back(row(ix(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 1, 1, EXP_T3, 1)));
    tbl.push_back(row(ix(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), o0));
    foreach (tbl[k]) cyc(tbl[k].i, tbl[k].o, $sformatf("tbl_%0d", k));

    // Writeback steals the port in the mcause cycle: everything slips one cycle
    t = ix(0, 0, 0, 0, 1, 32'h200, 32'h5, 32'h11, 32'h88, 32'h400);
    cyc(t, o0, "wb_t0");
    t.req = 0;
    cyc(t, ex(0, 0, 0, 1, 1, 0, 0, 0), "wb_flush");
    cyc(t, ex(1, 12'h341, 32'h200, 0, 1, 0, 0, 0), "wb_mepc");
    t.wb_we = 1; t.wa = 12'h340; t.wd = 32'h55;
    cyc(t, ex(1, 12'h340, 32'h55, 0, 1, 0, 0, 0), "wb_steal");
    t.wb_we = 0;
    cyc(t, ex(1, 12'h342, 32'h5, 0, 1, 0, 0, 0), "wb_mcause");
    cyc(t, ex(1, 12'h343, 32'h11, 0, 1, 0, 0, 0), "wb_mtval");
    cyc(t, ex(1, 12'h300, 32'h1880, 0, 1, 0, 0, 0), "wb_mstatus");
    cyc(t, ex(0, 0, 0, 0, 1, 1, 32'h400, 1), "wb_ack_t7");
    cyc(t, o0, "wb_idle");

    // Reset during the mtval write: no further writes, no ack
    t = ix(0, 0, 0, 0, 1, 32'h10, 32'h3, 32'h77, 32'h8, 32'h80);
    cyc(t, o0, "rst_t0");
    t.req = 0;
    cyc(t, ex(0, 0, 0, 1, 1, 0, 0, 0), "rst_flush");
    cyc(t, ex(1, 12'h341, 32'h10, 0, 1, 0, 0, 0), "rst_mepc");
    cyc(t, ex(1, 12'h342, 32'h3, 0, 1, 0, 0, 0), "rst_mcause");
    t.rst = 1;
    cyc(t, o0, "rst_in_mtval");
    t.rst = 0;
    for (int k = 0; k < 4; k++) cyc(t, o0, $sformatf("rst_after_%0d", k));

    // Vectored interrupt target (base only without the feature)
    t = ix(0, 0, 0, 0, 1, 32'h0, 32'h80000007, 32'h0, 32'h0, 32'h201);
    cyc(t, o0, "vec_t0");
    t.req = 0;
    cyc(t, ex(0, 0, 0, 1, 1, 0, 0, 0), "vec_flush");
    cyc(t, ex(1, 12'h341, 32'h0, 0, 1, 0, 0, 0), "vec_mepc");
    cyc(t, ex(1, 12'h342, 32'h80000007, 0, 1, 0, 0, 0), "vec_mcause");
    cyc(t, ex(1, 12'h343, 32'h0, 0, 1, 0, 0, 0), "vec_mtval");
    cyc(t, ex(1, 12'h300, 32'h1800, 0, 1, 0, 0, 0), "vec_mstatus");
    cyc(t, ex(0, 0, 0, 0, 1, 1, EXP_T5, 1), "vec_target");

    // Request held high through ack: one sequence, next starts from IDLE
    t = ix(0, 0, 0, 0, 1, 32'h40, 32'h1, 32'h2, 32'h0, 32'h100);
    cyc(t, o0, "hold_t0");
    cyc(t, ex(0, 0, 0, 1, 1, 0, 0, 0), "hold_flush");
    cyc(t, ex(1, 12'h341, 32'h40, 0, 1, 0, 0, 0), "hold_mepc");
    cyc(t, ex(1, 12'h342, 32'h1, 0, 1, 0, 0, 0), "hold_mcause");
    cyc(t, ex(1, 12'h343, 32'h2, 0, 1, 0, 0, 0), "hold_mtval");
    cyc(t, ex(1, 12'h300, 32'h1800, 0, 1, 0, 0, 0), "hold_mstatus");
    cyc(t, ex(0, 0, 0, 0, 1, 1, 32'h100, 1), "hold_ack");
    cyc(t, o0, "hold_idle");
    t.req = 0;
    cyc(t, ex(0, 0, 0, 1, 1, 0, 0, 0), "hold_reflush");

    // Random traffic against the reference model
    for (int k = 0; k < 800; k++) begin
      in_t  r;
      out_t e;
      r = ix($urandom_range(0, 59) == 0 || k == 0, $urandom_range(0, 2) == 0,
             12'($urandom), $urandom, $urandom_range(0, 2) == 0, $urandom, $urandom,
             $urandom, $urandom, $urandom);
      e = model_out(r);
      cyc(r, e, $sformatf("rand_%0d", k));
      model_step(r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
